// File: rtl/voice_mix_engine.sv
`default_nettype none
// ============================================================================
// Module   : voice_mix_engine
// Brief    : Time-shared MAC voice mixer with saturation and stereo panning.
// Revision : 1.0 - initial release
// ============================================================================
module voice_mix_engine #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 16
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [NUM_VOICES*GAIN_W-1:0]   gain,
    input  logic [15:0]                    pan,
    input  logic                           clear_flags,
    output logic [SAMPLE_W-1:0]            LDATA,
    output logic [SAMPLE_W-1:0]            RDATA,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           clip,
    output logic                           missed_tick
);

    localparam int c_idx_w = $clog2(NUM_VOICES);
    localparam int c_acc_w = SAMPLE_W + GAIN_W + c_idx_w + 1;
    // Coefficient operand holds either a zero-extended gain or a 15-bit pan weight.
    localparam int c_b_w   = ((GAIN_W > 15) ? GAIN_W : 15) + 1;
    localparam int c_p_w   = SAMPLE_W + c_b_w;

    localparam logic signed [c_acc_w-1:0] c_max =
        {{(c_acc_w-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_min =
        {{(c_acc_w-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_SAT   = 3'd2,
        S_PAN_L = 3'd3,
        S_PAN_R = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_VOICES*SAMPLE_W-1:0] voice_q;
    logic [NUM_VOICES-1:0]          en_q;
    logic [NUM_VOICES*GAIN_W-1:0]   gain_q;
    logic [14:0]                    pan_q;
    logic signed [c_acc_w-1:0]      acc_q;
    logic [c_idx_w-1:0]             idx_q;
    logic signed [SAMPLE_W-1:0]     mix_q, l_q, r_q;
    logic [SAMPLE_W-1:0]            ldata_q, rdata_q;
    logic                           valid_q, clip_q, missed_q;

    logic signed [SAMPLE_W-1:0]     w_op_a;
    logic signed [c_b_w-1:0]        w_op_b;
    logic signed [c_p_w-1:0]        w_prod, w_pan_full;
    logic signed [c_acc_w-1:0]      w_term, w_shift;
    logic signed [SAMPLE_W-1:0]     w_mix_sat;
    logic                           w_sat_hi, w_sat_lo;
    logic [14:0]                    w_pan_clamped;
    logic                           w_last;

    assign busy        = (state_q != S_IDLE);
    assign LDATA       = ldata_q;
    assign RDATA       = rdata_q;
    assign out_valid   = valid_q;
    assign clip        = clip_q;
    assign missed_tick = missed_q;

    assign w_pan_clamped = pan[15] ? 15'h7FFF : pan[14:0];
    assign w_last        = (idx_q == c_idx_w'(NUM_VOICES - 1));

    // The single multiplier serves the voice MAC and both pan products.
    always_comb begin
        w_op_a = voice_q[idx_q*SAMPLE_W +: SAMPLE_W];
        w_op_b = {{(c_b_w-GAIN_W){1'b0}}, gain_q[idx_q*GAIN_W +: GAIN_W]};
        case (state_q)
            S_PAN_L: begin
                w_op_a = mix_q;
                w_op_b = {{(c_b_w-15){1'b0}}, 15'h7FFF - pan_q};
            end
            S_PAN_R: begin
                w_op_a = mix_q;
                w_op_b = {{(c_b_w-15){1'b0}}, pan_q};
            end
            default: ;
        endcase
    end

    assign w_prod     = w_op_a * w_op_b;
    assign w_term     = en_q[idx_q] ? c_acc_w'(w_prod) : '0;
    assign w_pan_full = w_prod >>> 15;
    assign w_shift    = acc_q >>> (GAIN_W - 1);
    assign w_sat_hi   = (w_shift > c_max);
    assign w_sat_lo   = (w_shift < c_min);
    assign w_mix_sat  = w_sat_hi ? c_max[SAMPLE_W-1:0] :
                        w_sat_lo ? c_min[SAMPLE_W-1:0] : w_shift[SAMPLE_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_tick) state_d = S_ACCUM;
            S_ACCUM: if (w_last) state_d = S_SAT;
            S_SAT:   state_d = S_PAN_L;
            S_PAN_L: state_d = S_PAN_R;
            S_PAN_R: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            voice_q  <= '0;
            en_q     <= '0;
            gain_q   <= '0;
            pan_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            mix_q    <= '0;
            l_q      <= '0;
            r_q      <= '0;
            ldata_q  <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            clip_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            // A new set event takes priority over a simultaneous clear.
            missed_q <= (busy && sample_tick) || (missed_q && !clear_flags);
            clip_q   <= ((state_q == S_SAT) && (w_sat_hi || w_sat_lo)) ||
                        (clip_q && !clear_flags);
            case (state_q)
                S_IDLE: begin
                    if (sample_tick) begin
                        voice_q <= voice_in;
                        en_q    <= voice_en;
                        gain_q  <= gain;
                        pan_q   <= w_pan_clamped;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_q + w_term;
                    idx_q <= w_last ? '0 : idx_q + 1'b1;
                end
                S_SAT:   mix_q <= w_mix_sat;
                S_PAN_L: l_q   <= w_pan_full[SAMPLE_W-1:0];
                S_PAN_R: r_q   <= w_pan_full[SAMPLE_W-1:0];
                S_DONE: begin
                    ldata_q <= l_q;
                    rdata_q <= r_q;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_mix_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_mix_engine
// Brief    : Scoreboard bench for voice_mix_engine (8 voices, 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_mix_engine;

    localparam int NV = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sample_tick = 1'b0;
    logic [NV*16-1:0] voice_in = '0;
    logic [NV-1:0]  voice_en = '0;
    logic [NV*16-1:0] gain = '0;
    logic [15:0]    pan = '0;
    logic           clear_flags = 1'b0;
    logic [15:0]    LDATA, RDATA;
    logic           out_valid, busy, clip, missed_tick;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [15:0]    sb_l[$];
    logic [15:0]    sb_r[$];

    voice_mix_engine #(.NUM_VOICES(NV), .SAMPLE_W(16), .GAIN_W(16)) u_dut (
        .Clk(clk), .Reset(rst), .sample_tick(sample_tick),
        .voice_in(voice_in), .voice_en(voice_en), .gain(gain), .pan(pan),
        .clear_flags(clear_flags), .LDATA(LDATA), .RDATA(RDATA),
        .out_valid(out_valid), .busy(busy), .clip(clip), .missed_tick(missed_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference mix computed from the stimulus currently on the inputs.
    task automatic model(output logic [15:0] l, output logic [15:0] r);
        longint acc = 0;
        longint mix, p, lv, rv;
        for (int i = 0; i < NV; i++) begin
            if (voice_en[i])
                acc += longint'($signed(voice_in[i*16 +: 16])) * longint'(gain[i*16 +: 16]);
        end
        mix = acc >>> 15;
        if (mix > 32767)  mix = 32767;
        if (mix < -32768) mix = -32768;
        p  = (pan > 16'h7FFF) ? 32767 : longint'(pan);
        lv = (mix * (32767 - p)) >>> 15;
        rv = (mix * p) >>> 15;
        l  = lv[15:0];
        r  = rv[15:0];
    endtask

    task automatic set_all(input logic [15:0] v, input logic [15:0] g,
                           input logic [NV-1:0] en, input logic [15:0] pn);
        for (int i = 0; i < NV; i++) begin
            voice_in[i*16 +: 16] = v;
            gain[i*16 +: 16]     = g;
        end
        voice_en = en;
        pan      = pn;
    endtask

    // Tick once, optionally re-tick at cycle tick2_at and scramble inputs mid-mix.
    task automatic run_frame(input string tag, input int tick2_at, input bit mutate);
        logic [15:0] el, er;
        int cyc, pulses;
        model(el, er);
        sb_l.push_back(el);
        sb_r.push_back(er);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        cyc    = 0;
        pulses = 0;
        while (cyc < 24) begin
            sample_tick = (cyc == tick2_at);
            if (mutate && cyc == 2) begin
                voice_in = {$urandom, $urandom, $urandom, $urandom};
                gain     = {$urandom, $urandom, $urandom, $urandom};
                voice_en = NV'($urandom);
                pan      = 16'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) begin
                pulses++;
                if (pulses == 1 && sb_l.size() > 0) begin
                    check({tag, ".latency"}, cyc, NV + 4);
                    check({tag, ".L"}, LDATA, sb_l.pop_front());
                    check({tag, ".R"}, RDATA, sb_r.pop_front());
                end
            end
        end
        sample_tick = 1'b0;
        check({tag, ".pulses"}, pulses, 1);
        if (pulses == 0 && sb_l.size() > 0) begin
            void'(sb_l.pop_front());
            void'(sb_r.pop_front());
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        #1;
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clk);
        #1;
        check("rst.L", LDATA, 0);
        check("rst.R", RDATA, 0);
        check("rst.valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.clip", clip, 0);
        check("rst.missed", missed_tick, 0);
        @(negedge clk);
        rst = 1'b0;

        set_all(16'h0800, 16'h8000, '1, 16'h4000);
        run_frame("mix8", -1, 1'b0);
        check("mix8.clip", clip, 0);

        set_all(16'h7FFF, 16'h8000, 8'b0000_1000, 16'h7FFF);
        voice_in[3*16 +: 16] = 16'h1234;
        run_frame("solo3", -1, 1'b0);

        set_all(16'h8000, 16'hFFFF, '1, 16'h0000);
        run_frame("sat", -1, 1'b0);
        check("sat.clip", clip, 1);

        set_all(16'h0000, 16'h8000, 8'b0000_0001, 16'hFFFF);
        voice_in[15:0] = 16'h2000;
        run_frame("panclamp", -1, 1'b0);
        check("panclamp.clip_sticky", clip, 1);
        pulse_clear();
        check("clear.clip", clip, 0);

        set_all(16'h1000, 16'h4000, 8'b1010_0101, 16'h2345);
        run_frame("missed", 3, 1'b1);
        check("missed.flag", missed_tick, 1);
        pulse_clear();
        check("clear.missed", missed_tick, 0);

        set_all(16'h5A5A, 16'hFFFF, '0, 16'h1000);
        run_frame("alloff", -1, 1'b0);

        // Reset in the middle of accumulation after a frame with non-zero output.
        set_all(16'h0800, 16'h8000, '1, 16'h4000);
        run_frame("pre_rst", -1, 1'b0);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst.L", LDATA, 0);
        check("arst.R", RDATA, 0);
        check("arst.busy", busy, 0);
        check("arst.valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("arst.no_valid", pulses, 0);
        set_all(16'h0C00, 16'h6000, 8'b0111_1110, 16'h6000);
        run_frame("post_rst", -1, 1'b0);

        for (int n = 0; n < 4; n++) begin
            voice_in = {$urandom, $urandom, $urandom, $urandom};
            gain     = {$urandom, $urandom, $urandom, $urandom};
            voice_en = NV'($urandom);
            pan      = 16'($urandom);
            run_frame("rand", -1, 1'b0);
        end

        check("sb.empty", sb_l.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
